alu_sequencer: RTL and testbench

Initiator side of the ALU start/done handshake. Accepts one decoded ALU request at a time from the control unit and drives the ALU operation code, operands and start strobe. Waits for the ALU to complete, then writes the result to the register file and updates the Z/C/O/S status flags. Sits between instruction decode and the ALU.

---
 rtl/alu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Initiator side of the ALU start/done handshake: issues one decoded request, waits for done,
// writes the result back and updates Z/C/O/S. Optional wait-phase watchdog: ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
  parameter logic [7:0]  IDLE_OP        = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_dst,
  input  logic       req_we,
  output logic       alu_start,
  output logic [7:0] alu_cins,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_oe,
  output logic       alu_carryin,
  input  logic       alu_done,
  input  logic [7:0] alu_out,
  input  logic       alu_carryout,
  input  logic       alu_overout,
  input  logic       alu_cmpo,
  output logic       rf_we,
  output logic [1:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_o,
  output logic       flag_s,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_MODE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_CAPTURE, S_ERROR
  } state_t;

  localparam logic [7:0] OP_CLRCMP = 8'h50;

  state_t     state, state_nx;
  logic [7:0] op_q, a_q, b_q, res_q;
  logic [1:0] dst_q;
  logic       we_q, cout_q, oout_q, cmp_seen;
  logic       accept, is_mode, timeout_hit;

  assign is_mode = (req_op >= 8'h51) && (req_op <= 8'h54);
  assign accept  = req_valid && req_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          waiting;

  assign waiting = (state == S_WAIT_LO) || (state == S_WAIT_HI);

  // Counter restarts on every state change, so each wait phase gets its own budget
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wait_cnt <= '0;
    else if (state_nx != state) wait_cnt <= '0;
    else if (waiting)           wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout_hit = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = (state == S_ERROR);
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept) state_nx = is_mode ? S_MODE : S_ISSUE;
      S_MODE:    state_nx = S_IDLE;
      S_ISSUE:   state_nx = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!alu_done)        state_nx = S_WAIT_HI;
        else if (timeout_hit) state_nx = S_ERROR;
      end
      S_WAIT_HI: begin
        if (alu_done)         state_nx = S_CAPTURE;
        else if (timeout_hit) state_nx = S_ERROR;
      end
      S_CAPTURE: state_nx = S_IDLE;
      S_ERROR:   state_nx = S_ERROR;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    alu_start = 1'b0;
    alu_oe    = 1'b0;
    alu_cins  = IDLE_OP;
    rf_we     = 1'b0;
    case (state)
      S_IDLE:    req_ready = 1'b1;
      S_MODE:    alu_cins  = op_q;
      S_ISSUE: begin
        alu_start = 1'b1;
        alu_oe    = 1'b1;
        alu_cins  = op_q;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        alu_oe   = 1'b1;
        alu_cins = op_q;
      end
      S_CAPTURE: begin
        alu_oe   = 1'b1;
        alu_cins = op_q;
        rf_we    = we_q;
      end
      default: ;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_carryin = flag_c;
  assign rf_waddr    = dst_q;
  assign rf_wdata    = res_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      we_q     <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      oout_q   <= 1'b0;
      cmp_seen <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_o   <= 1'b0;
      flag_s   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        dst_q <= req_dst;
        we_q  <= req_we;
      end
      case (state)
        S_ISSUE:   cmp_seen <= 1'b0;
        S_WAIT_LO: if (alu_cmpo) cmp_seen <= 1'b1;
        S_WAIT_HI: begin
          if (alu_cmpo) cmp_seen <= 1'b1;
          if (alu_done) begin
            res_q  <= alu_out;
            cout_q <= alu_carryout;
            oout_q <= alu_overout;
          end
        end
        S_CAPTURE: begin
          if (op_q == OP_CLRCMP) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_o <= 1'b0;
            flag_s <= 1'b0;
          end else if (cmp_seen) begin
            flag_z <= (res_q == 8'h00);
            flag_s <= res_q[7];
            flag_c <= cout_q;
            flag_o <= oout_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU model on the start/done handshake,
// scoreboard of expected register-file writes.
module tb_alu_sequencer;

  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_ADC    = 8'h02;
  localparam logic [7:0] OP_CMP    = 8'h10;
  localparam logic [7:0] OP_CLRCMP = 8'h50;
  localparam logic [7:0] OP_SIGNON = 8'h52;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [7:0] req_op = '0, req_a = '0, req_b = '0;
  logic [1:0] req_dst = '0;
  logic       alu_start, alu_oe, alu_carryin;
  logic [7:0] alu_cins, alu_a, alu_b;
  logic       alu_done = 1'b1, alu_carryout = 1'b0, alu_overout = 1'b0, alu_cmpo = 1'b0;
  logic [7:0] alu_out = '0;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       flag_z, flag_c, flag_o, flag_s, busy, err_timeout;

  alu_sequencer #(.IDLE_OP(8'h00), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_dst(req_dst), .req_we(req_we),
    .alu_start(alu_start), .alu_cins(alu_cins), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oe(alu_oe), .alu_carryin(alu_carryin), .alu_done(alu_done), .alu_out(alu_out),
    .alu_carryout(alu_carryout), .alu_overout(alu_overout), .alu_cmpo(alu_cmpo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_z(flag_z), .flag_c(flag_c), .flag_o(flag_o), .flag_s(flag_s),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [1:0] dst; logic [7:0] data; logic we; } exp_t;
  exp_t sb[$];
  exp_t e;

  // ALU model: registers start, holds done low for m_lat cycles, then presents the result
  int         m_lat = 3;
  bit         m_stuck = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_op, m_a, m_b;
  logic       m_cin;
  logic [8:0] m_sum;

  always @(negedge clk) begin
    if (!rst) begin
      m_cnt = 0;
      alu_done = 1'b1;
      alu_cmpo = 1'b0;
    end else if (alu_start) begin
      m_op = alu_cins; m_a = alu_a; m_b = alu_b; m_cin = alu_carryin;
      m_cnt = m_lat;
      alu_cmpo = (alu_cins == OP_CMP);
      if (!m_stuck) alu_done = 1'b0;
    end else if (m_cnt > 0 && !m_stuck) begin
      m_cnt--;
      if (m_cnt == 0) begin
        case (m_op)
          OP_ADD:  m_sum = {1'b0, m_a} + {1'b0, m_b};
          OP_ADC:  m_sum = {1'b0, m_a} + {1'b0, m_b} + {8'b0, m_cin};
          OP_CMP:  begin m_sum[7:0] = m_a - m_b; m_sum[8] = (m_a >= m_b); end
          default: m_sum = '0;
        endcase
        alu_out      = m_sum[7:0];
        alu_carryout = m_sum[8];
        alu_overout  = (m_op == OP_CMP) ? ((m_a[7] ^ m_b[7]) & (m_a[7] ^ m_sum[7]))
                                        : (~(m_a[7] ^ m_b[7]) & (m_a[7] ^ m_sum[7]));
        alu_done = 1'b1;
        alu_cmpo = 1'b0;
      end
    end
  end

  // Drives one request (called at a negedge) and observes until the sequencer is idle again
  task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] dst, input logic we, input int lat,
                        output int starts, output int busy_cycles, output int cins_cycles,
                        output bit saw_we, output logic [1:0] waddr, output logic [7:0] wdata);
    int n;
    m_lat = lat;
    req_op = op; req_a = a; req_b = b; req_dst = dst; req_we = we; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    starts = 0; busy_cycles = 0; cins_cycles = 0; saw_we = 1'b0; waddr = '0; wdata = '0;
    while (busy && busy_cycles < 200) begin
      if (alu_start) starts++;
      if (alu_cins == op) cins_cycles++;
      if (rf_we) begin saw_we = 1'b1; waddr = rf_waddr; wdata = rf_wdata; end
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({alu_start, alu_oe, rf_we, busy, err_timeout, req_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctrl: start/oe/rf_we/busy/err/ready got %b want 000001",
               {alu_start, alu_oe, rf_we, busy, err_timeout, req_ready});
    end
    checks++;
    if ({alu_cins, alu_a, alu_b, rf_waddr, rf_wdata} !== 34'd0) begin
      failures++;
      $display("FAIL reset_data: cins=%h a=%h b=%h waddr=%0d wdata=%h want all 0",
               alu_cins, alu_a, alu_b, rf_waddr, rf_wdata);
    end
    checks++;
    if ({flag_z, flag_s, flag_c, flag_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: zsco got %b want 0000", {flag_z, flag_s, flag_c, flag_o});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_compute;
    int st, bc, cc; bit sw; logic [1:0] wa; logic [7:0] wd;
    // Compare 0x80 vs 0x80: result 0, carry set, cmpo raised -> Z=1 S=0 C=1 O=0
    sb.push_back('{2'd1, 8'h00, 1'b1});
    run_op(OP_CMP, 8'h80, 8'h80, 2'd1, 1'b1, 3, st, bc, cc, sw, wa, wd);
    e = sb.pop_front();
    checks++;
    if (sw !== e.we || wa !== e.dst || wd !== e.data) begin
      failures++;
      $display("FAIL cmp_rf: we=%b addr=%0d data=%h want we=%b addr=%0d data=%h", sw, wa, wd, e.we, e.dst, e.data);
    end
    checks++;
    if ({flag_z, flag_s, flag_c, flag_o} !== 4'b1010) begin
      failures++;
      $display("FAIL cmp_flags: zsco got %b want 1010", {flag_z, flag_s, flag_c, flag_o});
    end
    // ADD 3+4 without cmpo: write 7 to r2, flags keep the compare result
    sb.push_back('{2'd2, 8'h07, 1'b1});
    run_op(OP_ADD, 8'h03, 8'h04, 2'd2, 1'b1, 2, st, bc, cc, sw, wa, wd);
    e = sb.pop_front();
    checks++;
    if (sw !== e.we || wa !== e.dst || wd !== e.data) begin
      failures++;
      $display("FAIL add_rf: we=%b addr=%0d data=%h want we=%b addr=%0d data=%h", sw, wa, wd, e.we, e.dst, e.data);
    end
    checks++;
    if (st !== 1) begin
      failures++;
      $display("FAIL add_start_pulses: got %0d want 1", st);
    end
    checks++;
    if (bc !== 4) begin
      failures++;
      $display("FAIL add_busy_cycles: got %0d want 4", bc);
    end
    checks++;
    if ({flag_z, flag_s, flag_c, flag_o} !== 4'b1010) begin
      failures++;
      $display("FAIL add_flags_held: zsco got %b want 1010", {flag_z, flag_s, flag_c, flag_o});
    end
    // Clear-compare with we=0: no write, all flags cleared
    sb.push_back('{2'd0, 8'h00, 1'b0});
    run_op(OP_CLRCMP, 8'h00, 8'h00, 2'd0, 1'b0, 2, st, bc, cc, sw, wa, wd);
    e = sb.pop_front();
    checks++;
    if (sw !== e.we) begin
      failures++;
      $display("FAIL clr_rf_we: got %b want %b", sw, e.we);
    end
    checks++;
    if ({flag_z, flag_s, flag_c, flag_o} !== 4'b0000) begin
      failures++;
      $display("FAIL clr_flags: zsco got %b want 0000", {flag_z, flag_s, flag_c, flag_o});
    end
  endtask

  task automatic test_mode;
    int st, bc, cc; bit sw; logic [1:0] wa; logic [7:0] wd;
    run_op(OP_SIGNON, 8'h00, 8'h00, 2'd3, 1'b1, 3, st, bc, cc, sw, wa, wd);
    checks++;
    if (st !== 0) begin
      failures++;
      $display("FAIL mode_start: pulses got %0d want 0", st);
    end
    checks++;
    if (cc !== 1) begin
      failures++;
      $display("FAIL mode_cins_cycles: got %0d want 1", cc);
    end
    checks++;
    if (sw !== 1'b0) begin
      failures++;
      $display("FAIL mode_rf_we: got %b want 0", sw);
    end
    checks++;
    if (bc !== 1 || req_ready !== 1'b1 || alu_cins !== 8'h00) begin
      failures++;
      $display("FAIL mode_return: busy_cycles=%0d ready=%b cins=%h want 1 1 00", bc, req_ready, alu_cins);
    end
  endtask

  task automatic test_back_to_back;
    int n, cap_cycle, start2;
    logic ready_in_cap, carry_at_start;
    logic [1:0] wa1, wa2; logic [7:0] wd1, wd2; bit sw2;
    exp_t e1, e2;
    // 0x80 - 0x01 = 0x7F with C=1 O=1; then ADC 1+1+C = 3
    sb.push_back('{2'd3, 8'h7F, 1'b1});
    sb.push_back('{2'd0, 8'h03, 1'b1});
    m_lat = 3;
    req_op = OP_CMP; req_a = 8'h80; req_b = 8'h01; req_dst = 2'd3; req_we = 1'b1; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_op = OP_ADC; req_a = 8'h01; req_b = 8'h01; req_dst = 2'd0; req_we = 1'b1;
    n = 0; cap_cycle = -1; start2 = -1;
    ready_in_cap = 1'bx; carry_at_start = 1'bx; wa1 = '0; wd1 = '0;
    while (n < 100 && start2 < 0) begin
      if (rf_we && cap_cycle < 0) begin
        cap_cycle = n; wa1 = rf_waddr; wd1 = rf_wdata; ready_in_cap = req_ready;
      end
      if (alu_start && n > 0) begin
        start2 = n; carry_at_start = alu_carryin; req_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    n = 0; sw2 = 1'b0; wa2 = '0; wd2 = '0;
    while (busy && n < 100) begin
      if (rf_we) begin sw2 = 1'b1; wa2 = rf_waddr; wd2 = rf_wdata; end
      @(negedge clk);
      n++;
    end
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    checks++;
    if (cap_cycle < 0 || wa1 !== e1.dst || wd1 !== e1.data) begin
      failures++;
      $display("FAIL b2b_first_rf: cyc=%0d addr=%0d data=%h want addr=%0d data=%h", cap_cycle, wa1, wd1, e1.dst, e1.data);
    end
    checks++;
    if (ready_in_cap !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_in_capture: got %b want 0", ready_in_cap);
    end
    checks++;
    if (cap_cycle < 0 || start2 !== cap_cycle + 2) begin
      failures++;
      $display("FAIL b2b_accept_timing: second start at %0d capture at %0d want capture+2", start2, cap_cycle);
    end
    checks++;
    if (carry_at_start !== 1'b1) begin
      failures++;
      $display("FAIL b2b_carryin: got %b want 1", carry_at_start);
    end
    checks++;
    if (sw2 !== e2.we || wa2 !== e2.dst || wd2 !== e2.data) begin
      failures++;
      $display("FAIL b2b_second_rf: we=%b addr=%0d data=%h want we=%b addr=%0d data=%h", sw2, wa2, wd2, e2.we, e2.dst, e2.data);
    end
    checks++;
    if ({flag_z, flag_s, flag_c, flag_o} !== 4'b0011) begin
      failures++;
      $display("FAIL b2b_flags: zsco got %b want 0011", {flag_z, flag_s, flag_c, flag_o});
    end
  endtask

  task automatic test_reset_mid;
    int st, bc, cc, n, writes; bit sw; logic [1:0] wa; logic [7:0] wd;
    run_op(OP_CMP, 8'h80, 8'h80, 2'd1, 1'b1, 2, st, bc, cc, sw, wa, wd);
    sb.push_back('{2'd2, 8'h0B, 1'b1});
    m_lat = 6;
    req_op = OP_ADD; req_a = 8'h05; req_b = 8'h06; req_dst = 2'd2; req_we = 1'b1; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_oe !== 1'b1 || alu_done !== 1'b0 || flag_z !== 1'b1) begin
      failures++;
      $display("FAIL mid_wait_setup: busy=%b oe=%b done=%b z=%b want 1 1 0 1", busy, alu_oe, alu_done, flag_z);
    end
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({alu_start, alu_oe, rf_we, busy, req_ready} !== 5'b00001 || alu_cins !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_ctrl: start/oe/rf_we/busy/ready=%b cins=%h want 00001 00",
               {alu_start, alu_oe, rf_we, busy, req_ready}, alu_cins);
    end
    checks++;
    if ({flag_z, flag_s, flag_c, flag_o} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_flags: zsco got %b want 0000", {flag_z, flag_s, flag_c, flag_o});
    end
    rst = 1'b1;
    writes = 0;
    repeat (10) begin
      @(negedge clk);
      if (rf_we) writes++;
    end
    checks++;
    if (writes !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_discard: rf writes=%0d busy=%b want 0 0", writes, busy);
    end
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int n, held;
    m_stuck = 1'b1;
    req_op = OP_ADD; req_a = 8'h01; req_b = 8'h01; req_dst = 2'd1; req_we = 1'b1; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!err_timeout && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL timeout_latency: err after %0d cycles from issue want 33", n);
    end
    held = 0;
    repeat (5) begin
      if (err_timeout === 1'b1 && req_ready === 1'b0 && rf_we === 1'b0 && alu_oe === 1'b0) held++;
      @(negedge clk);
    end
    checks++;
    if (held !== 5) begin
      failures++;
      $display("FAIL timeout_sticky: held %0d of 5 cycles want 5", held);
    end
    m_stuck = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_reset: err=%b ready=%b want 0 1", err_timeout, req_ready);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_compute();
    test_mode();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

endmodule
